// File: rtl/selftest_sequencer_if.sv
// Core data-memory write port plus expected-result ROM output,
// as seen by the self-test sequencer.
interface selftest_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  memwrite;
  logic [ADDR_WIDTH-1:0] dataadr;
  logic [DATA_WIDTH-1:0] writedata;
  logic [ADDR_WIDTH-1:0] exp_adr;
  logic [DATA_WIDTH-1:0] exp_data;

  modport master (
    output memwrite, dataadr, writedata,
    output exp_adr, exp_data
  );

  modport slave (
    input memwrite, dataadr, writedata,
    input exp_adr, exp_data
  );
endinterface

// File: rtl/selftest_sequencer.sv
// Runs the core through a bank of test programs, one expected
// store per test, and keeps pass/fail results for the whole pass.
module selftest_sequencer #(
  parameter int NUM_TESTS       = 13,
  parameter int CYCLES_PER_TEST = 100,
  parameter int RESET_CYCLES    = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter bit EARLY_EXIT      = 1'b0,
  localparam int IDXW =
    (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  selftest_sequencer_if.slave  bus,
  output logic                 cpu_reset,
  output logic [IDXW-1:0]      test_idx,
  output logic                 busy,
  output logic                 done,
  output logic [IDXW:0]        pass_count,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [15:0]          mismatch_count
);
  localparam int CW = (CYCLES_PER_TEST > 2) ?
    $clog2(CYCLES_PER_TEST) : 1;
  localparam int RW = (RESET_CYCLES > 1) ?
    $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST =
    CW'(CYCLES_PER_TEST - 1);
  localparam logic [RW-1:0] R_LAST =
    RW'(RESET_CYCLES - 1);
  localparam logic [IDXW-1:0] I_LAST =
    IDXW'(NUM_TESTS - 1);

  typedef enum logic [2:0] {
    IDLE, RESET_DUT, RUN, SCORE, DONE
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic hit_q, hit_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW:0] pass_q, pass_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [15:0] mism_q, mism_d;
  logic cpu_reset_q, cpu_reset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] wdat;
  logic wr, match;

  assign adr   = bus.dataadr;
  assign wdat  = bus.writedata;
  assign wr    = bus.memwrite;
  assign match = wr && (adr == bus.exp_adr) &&
                 (wdat == bus.exp_data);

  // State and result registers; async reset aborts a pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      ccnt_q      <= '0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      mism_q      <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      ccnt_q      <= ccnt_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      mism_q      <= mism_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state; status outputs follow the next state so they
  // are registered alongside it.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    ccnt_d  = ccnt_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    mism_d  = mism_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RESET_DUT;
          rcnt_d  = '0;
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          mism_d  = '0;
        end
      end
      RESET_DUT: begin
        if (rcnt_q == R_LAST) begin
          state_d = RUN;
          ccnt_d  = '0;
          hit_d   = 1'b0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      RUN: begin
        ccnt_d = ccnt_q + CW'(1);
        if (match) begin
          hit_d = 1'b1;
        end else if (wr && mism_q != 16'hFFFF) begin
          mism_d = mism_q + 16'd1;
        end
        if (ccnt_q == C_LAST || (EARLY_EXIT && match)) begin
          state_d = SCORE;
        end
      end
      SCORE: begin
        if (hit_q) begin
          pass_d = pass_q + (IDXW+1)'(1);
        end else begin
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q == I_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          rcnt_d  = '0;
          state_d = RESET_DUT;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_reset_d = (state_d != RUN);
    busy_d = (state_d == RESET_DUT) ||
             (state_d == RUN) || (state_d == SCORE);
    done_d = (state_d == DONE);
  end

  assign cpu_reset      = cpu_reset_q;
  assign test_idx       = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_mask      = fail_q;
  assign mismatch_count = mism_q;
endmodule

// File: tb/tb_selftest_sequencer.sv
// Directed bench for selftest_sequencer: normal and early-exit
// instances, scripted stores per test and cycle.
module tb_selftest_sequencer;
  localparam int N = 3;
  localparam int C = 8;
  localparam int R = 2;
  localparam logic [31:0] EA = 32'h14;
  localparam logic [31:0] ED = 32'd21;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic        cr0, busy0, done0;
  logic [1:0]  idx0;
  logic [2:0]  pass0;
  logic [2:0]  mask0;
  logic [15:0] mism0;
  logic        cr1, busy1, done1;
  logic [1:0]  idx1;
  logic [2:0]  pass1;
  logic [2:0]  mask1;
  logic [15:0] mism1;

  int ntests = 0;
  int nfail = 0;

  selftest_sequencer_if #(32, 32) bus0 ();
  selftest_sequencer_if #(32, 32) bus1 ();

  selftest_sequencer #(
    .NUM_TESTS(N), .CYCLES_PER_TEST(C),
    .RESET_CYCLES(R), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .EARLY_EXIT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .start(start0),
    .bus(bus0.slave), .cpu_reset(cr0),
    .test_idx(idx0), .busy(busy0), .done(done0),
    .pass_count(pass0), .fail_mask(mask0),
    .mismatch_count(mism0)
  );

  selftest_sequencer #(
    .NUM_TESTS(N), .CYCLES_PER_TEST(C),
    .RESET_CYCLES(R), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .EARLY_EXIT(1'b1)
  ) dut_e (
    .clk(clk), .reset(reset), .start(start1),
    .bus(bus1.slave), .cpu_reset(cr1),
    .test_idx(idx1), .busy(busy1), .done(done1),
    .pass_count(pass1), .fail_mask(mask1),
    .mismatch_count(mism1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Store to issue in test 'tst' at offset 'o' of that test
  // (offsets 0..R-1 reset, R..R+C-1 run, then score).
  function automatic void stim(input int scen,
                               input int tst,
                               input int o,
                               output logic v,
                               output logic [31:0] a,
                               output logic [31:0] d);
    int j;
    j = o - R;
    v = 1'b0;
    a = 32'h0;
    d = 32'h0;
    if (tst < N) begin
      case (scen)
        0: if (j == 3) begin v = 1; a = EA; d = ED; end
        1: begin
          if (tst == 0 && j == 3) begin
            v = 1; a = EA; d = ED;
          end
          if (tst == 1 && o == 1) begin
            v = 1; a = EA; d = ED;
          end
          if (tst == 1 && o == R + C) begin
            v = 1; a = 32'h18; d = 32'd5;
          end
          if (tst == 2 && j == 7) begin
            v = 1; a = EA; d = ED;
          end
        end
        2: begin
          if (tst == 0 && j == 1) begin
            v = 1; a = EA; d = 32'd20;
          end
          if (tst == 0 && j == 2) begin
            v = 1; a = 32'h18; d = ED;
          end
          if (j == 3) begin v = 1; a = EA; d = ED; end
        end
        3: if (j == 0) begin v = 1; a = EA; d = ED; end
        default: v = 1'b0;
      endcase
    end
  endfunction

  task automatic run_pass(input int scen, input int ee,
                          input int glitch_t,
                          input int abort_t,
                          output int done_t);
    int per;
    logic v;
    logic [31:0] a, d;
    per = ee ? (R + 2) : (R + C + 1);
    if (ee != 0) start1 = 1'b1;
    else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    done_t = -1;
    for (int t = 1; t <= 200; t++) begin
      stim(scen, (t - 1) / per, (t - 1) % per, v, a, d);
      if (ee != 0) begin
        bus1.memwrite = v;
        bus1.dataadr = a;
        bus1.writedata = d;
      end else begin
        bus0.memwrite = v;
        bus0.dataadr = a;
        bus0.writedata = d;
        start0 = (t == glitch_t);
      end
      @(posedge clk);
      @(negedge clk);
      if (ee == 0 && t == 1) check("cr_in_reset", cr0, 1);
      if (ee == 0 && t == 1) check("busy_early", busy0, 1);
      if (ee == 0 && t == R) check("cr_in_run", cr0, 0);
      if (t == abort_t) begin
        check("abort_idx", idx0, 1);
        check("abort_cr", cr0, 0);
        check("abort_pass", pass0, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_rst_cr", cr0, 1);
        check("abort_rst_busy", busy0, 0);
        check("abort_rst_idx", idx0, 0);
        check("abort_rst_pass", pass0, 0);
        @(negedge clk);
        reset = 1'b0;
        done_t = -2;
        break;
      end
      if ((ee != 0 ? done1 : done0) === 1'b1) begin
        done_t = t;
        break;
      end
    end
    bus0.memwrite = 1'b0;
    bus1.memwrite = 1'b0;
    start0 = 1'b0;
  endtask

  initial begin
    int dt;
    bus0.memwrite = 1'b0;
    bus0.dataadr = '0;
    bus0.writedata = '0;
    bus0.exp_adr = EA;
    bus0.exp_data = ED;
    bus1.memwrite = 1'b0;
    bus1.dataadr = '0;
    bus1.writedata = '0;
    bus1.exp_adr = EA;
    bus1.exp_data = ED;

    #2 reset = 1'b1;
    #1;
    check("rst_cr", cr0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_mask", mask0, 0);
    check("rst_mism", mism0, 0);
    check("rst_idx", idx0, 0);
    check("rst_e_busy", busy1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_pass(0, 0, -1, -1, dt);
    check("allpass_done_t", dt, 33);
    check("allpass_pass", pass0, 3);
    check("allpass_mask", mask0, 0);
    check("allpass_mism", mism0, 0);
    check("allpass_busy", busy0, 0);
    check("allpass_idx", idx0, 2);
    check("allpass_cr", cr0, 1);

    run_pass(1, 0, -1, -1, dt);
    check("silent_done_t", dt, 33);
    check("silent_pass", pass0, 2);
    check("silent_mask", mask0, 3'b010);
    check("silent_mism", mism0, 0);

    run_pass(2, 0, -1, -1, dt);
    check("wrong_pass", pass0, 3);
    check("wrong_mask", mask0, 0);
    check("wrong_mism", mism0, 2);

    run_pass(3, 1, -1, -1, dt);
    check("early_done_t", dt, 12);
    check("early_pass", pass1, 3);
    check("early_mask", mask1, 0);

    run_pass(0, 0, 5, R + C + 1 + R + 1, dt);
    check("abort_reached", dt, -2);
    repeat (3) @(negedge clk);
    check("abort_idle_busy", busy0, 0);
    check("abort_idle_done", done0, 0);

    run_pass(0, 0, -1, -1, dt);
    check("restart_done_t", dt, 33);
    check("restart_pass", pass0, 3);
    check("restart_mask", mask0, 0);
    check("restart_mism", mism0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/selftest_sequencer.md
# selftest_sequencer

Synthesizable self-test sequencer for the MIPS core. It drives the core's reset through NUM_TESTS back-to-back test programs and gives each test a fixed cycle budget. During each test it watches the data-memory write port for one expected (address, data) store and records a per-test pass/fail result. It sits beside `top` on the FPGA build, takes the expected-result ROM as input, and exposes its summary outputs to LEDs or a debug register.

## Interface
Parameters:
- NUM_TESTS, 13, number of test programs run per pass
- CYCLES_PER_TEST, 100, RUN-phase cycle budget per test (≥2)
- RESET_CYCLES, 2, cycles cpu_reset is held before each test (≥1)
- ADDR_WIDTH, 32, width of dataadr/exp_adr
- DATA_WIDTH, 32, width of writedata/exp_data
- EARLY_EXIT, 0, 1 = end RUN on the first matching store

Ports (IDXW = max(1, clog2(NUM_TESTS))):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset of this block
- start  in  1  single-cycle request to begin a full pass
- memwrite  in  1  core data-memory write strobe
- dataadr  in  ADDR_WIDTH  core write address
- writedata  in  DATA_WIDTH  core write data
- exp_adr  in  ADDR_WIDTH  expected store address for test_idx (ROM output, combinational)
- exp_data  in  DATA_WIDTH  expected store data for test_idx
- cpu_reset  out  1  reset to the core; also selects the imem program bank with test_idx
- test_idx  out  IDXW  index of the current test
- busy  out  1  pass in progress
- done  out  1  pass complete, results valid
- pass_count  out  IDXW+1  number of passing tests
- fail_mask  out  NUM_TESTS  bit i set = test i failed
- mismatch_count  out  16  non-matching stores seen; saturates at 0xFFFF

## Operation
- States: IDLE, RESET_DUT, RUN, SCORE, DONE.
- Async reset values: state=IDLE, cpu_reset=1, test_idx=0, busy=0, done=0, pass_count=0, fail_mask=0, mismatch_count=0. Internal cycle counter and hit flag are cleared.
- IDLE/DONE, start=1:
  - clear pass_count, fail_mask, mismatch_count, test_idx and done
  - go to RESET_DUT with busy=1
  - start is ignored in all other states.
- RESET_DUT: cpu_reset=1 for RESET_CYCLES cycles, then go to RUN with cycle counter=0 and hit=0.
- RUN: cpu_reset=0. Each rising edge with memwrite=1:
  - if dataadr==exp_adr and writedata==exp_data, set hit=1
  - otherwise increment mismatch_count (saturating).
  - After a hit, further stores still compare. Non-matching stores still increment mismatch_count, and the hit stays sticky.
- RUN exit:
  - after CYCLES_PER_TEST cycles
  - or, when EARLY_EXIT=1, on the edge where a match is captured.
  - Either exit goes to SCORE.
- SCORE (1 cycle, cpu_reset=1):
  - if hit, pass_count += 1; otherwise fail_mask[test_idx] = 1
  - if test_idx==NUM_TESTS-1, go to DONE; otherwise increment test_idx and go to RESET_DUT.
- DONE: busy=0, done=1, cpu_reset=1 (core held). test_idx holds NUM_TESTS-1. Results are held until start or reset.
- cpu_reset is 1 in every state except RUN.

## Timing
- All outputs are registered and change only on the rising clk edge, except on async reset.
- Start at edge k:
  - RESET_DUT occupies cycles k+1 … k+RESET_CYCLES.
  - RUN occupies the next CYCLES_PER_TEST cycles.
  - SCORE occupies the next cycle.
- Per-test length without early exit is RESET_CYCLES+CYCLES_PER_TEST+1 cycles. done rises NUM_TESTS×(that) cycles after the start edge.
- A matching store on the last RUN cycle counts.
- A store with cpu_reset=1 is not evaluated.
- With EARLY_EXIT=1, a match on RUN cycle j (0-based) gives SCORE on cycle j+1 of the test.
- Reset mid-pass aborts immediately: all outputs go to their reset values and the partial results are discarded. A new start is required.
- exp_adr/exp_data must be valid combinationally from test_idx. They change only after SCORE.

## Test plan
Common settings unless stated: NUM_TESTS=3, CYCLES_PER_TEST=8, RESET_CYCLES=2, EARLY_EXIT=0. Expected values for every test are exp=(0x14, 21).

- Reset check: assert reset mid-clock, before any clk edge → cpu_reset=1, busy=0, done=0, pass_count=0, fail_mask=0, mismatch_count=0.
- All pass: store (0x14, 21) on RUN cycle 3 of each test → done rises exactly 33 cycles after the start edge; pass_count=3, fail_mask=3'b000, mismatch_count=0.
- One test silent, one late store:
  - test 1 issues no store → fail_mask=3'b010, pass_count=2
  - test 2's match lands on RUN cycle 7 and still passes.
- Wrong stores then match: test 0 stores (0x14, 20) and (0x18, 21), then (0x14, 21) → test 0 passes; final mismatch_count=2.
- EARLY_EXIT=1: match on RUN cycle 0 of every test → each test takes 4 cycles; done rises 12 cycles after start; pass_count=3.
- Abort and restart:
  - start pulse while busy → ignored, no state change
  - reset asserted during test 1 RUN → immediate reset values
  - fresh start → full pass, results as in the all-pass case.
